cmd_router: RTL and testbench
=============================

CMD_ROUTER -- requirements
Module: cmd_router

Parameters
REQ-001 DAC_W, default 16, DAC word width in bits; SHALL be a multiple of 8, range 8..32.
REQ-002 NPOT, default 4, number of digital-pot channels, range 2..16.
REQ-003 POT_W, default 8, pot wiper word width, fixed at 8.
REQ-004 TIMEOUT, default 1000, idle clocks allowed between bytes of one frame before abort, minimum 2.
REQ-005 CH_W = max(1, clog2(NPOT)), derived.

Interface
REQ-006 clk  in  1  single system clock; all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 data_in  in  8  received byte; synchronous to clk; valid while tx_send high.
REQ-009 tx_send  in  1  byte-ready level from UART receiver; may stay high for any number of cycles.
REQ-010 data_out  out  8  response byte (ACK 0x06 / NAK 0x15).
REQ-011 data_out_valid  out  1  one-cycle pulse qualifying data_out.
REQ-012 ctrl_dac  out  1  one-cycle load strobe to DAC driver.
REQ-013 dato_dac  out  DAC_W  DAC word, held until next DAC command.
REQ-014 mux_dpot  out  CH_W  selected pot channel, held.
REQ-015 ctrl_dpot  out  1  one-cycle load strobe to pot driver.
REQ-016 dato_dpot  out  POT_W  pot wiper value, held.
REQ-017 seg  out  2  current parser state code.

Function
REQ-018 A byte SHALL be accepted only on a clock edge where tx_send=1 and the registered previous tx_send=0; a held-high tx_send yields exactly one byte.
REQ-019 Frame formats: DAC = 0x44 then DAC_W/8 data bytes MSB first; POT = 0x50, channel byte, one data byte.
REQ-020 States and seg codes: IDLE=0, GET_CH=1, GET_DATA=2, ISSUE=3.
REQ-021 IDLE: 0x44 -> GET_DATA with byte count DAC_W/8; 0x50 -> GET_CH; any other byte -> NAK, stay IDLE.
REQ-022 GET_CH: channel < NPOT -> latch channel, GET_DATA with count 1; channel >= NPOT -> NAK, IDLE.
REQ-023 GET_DATA: shift each accepted byte into a DAC_W-bit staging register (MSB first); accepting the last byte -> ISSUE.
REQ-024 ISSUE lasts exactly one cycle: SHALL load dato_dac or {mux_dpot, dato_dpot} from staging, pulse ctrl_dac or ctrl_dpot high for that cycle, pulse data_out_valid with data_out=0x06, then return to IDLE.
REQ-025 Latency: strobe and ACK SHALL be high in the cycle immediately after the edge that accepted the final byte.
REQ-026 Held outputs (dato_dac, mux_dpot, dato_dpot) SHALL change only in ISSUE of the matching command type; NAK or abort never modifies them.
REQ-027 A cycle counter SHALL clear on every accepted byte and count while in GET_CH or GET_DATA; reaching TIMEOUT -> NAK, IDLE, staging cleared.
REQ-028 A byte accepted in the same cycle the counter reaches TIMEOUT SHALL win: byte processed, counter cleared, no NAK.
REQ-029 A byte edge occurring while in ISSUE SHALL be accepted as the first byte of a new frame (treated as IDLE input).
REQ-030 ctrl_dac, ctrl_dpot and data_out_valid SHALL never be high in the same cycle as each other except ctrl_* with data_out_valid in ISSUE.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, seg=0, all outputs, staging, counter and edge register to 0, regardless of frame progress.
REQ-032 First byte accepted after rst_n release requires a fresh 0->1 tx_send transition.

Verification
REQ-033 DAC write: bytes 0x44,0x12,0x34 -> one-cycle ctrl_dac, dato_dac=0x1234, data_out=0x06 with data_out_valid, seg back to 0.
REQ-034 Pot write: 0x50,0x02,0xA5 -> mux_dpot=2, dato_dpot=0xA5, one-cycle ctrl_dpot, ACK; dato_dac unchanged.
REQ-035 Bad header 0x74, then bad channel 0x50,0x05 (NPOT=4) -> two NAKs (0x15), no ctrl strobes, seg=0 after each.
REQ-036 Timeout: 0x44,0x12 then no tx_send for TIMEOUT cycles -> NAK exactly at count TIMEOUT, dato_dac unchanged; following full frame 0x44,0xAB,0xCD -> dato_dac=0xABCD.
REQ-037 tx_send held high 10 cycles with data_in=0x44 -> single byte accepted (seg=2); rst_n pulsed low mid-frame -> all outputs 0, seg=0 asynchronously.
REQ-038 Parameter sweep DAC_W=24, NPOT=8: 0x44,0x01,0x02,0x03 -> dato_dac=0x010203; 0x50,0x07,0x3C -> mux_dpot=7.

Source files
------------

// File: rtl/cmd_router.sv
// Byte-stream command parser: 0x44 + DAC_W/8 bytes (MSB first) loads the DAC word,
// 0x50 + channel + wiper loads a digital pot; each frame is answered with ACK 0x06 or NAK 0x15.
module cmd_router #(
    parameter int DAC_W   = 16,
    parameter int NPOT    = 4,
    parameter int POT_W   = 8,
    parameter int TIMEOUT = 1000,
    localparam int CH_W   = (NPOT > 1) ? $clog2(NPOT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       data_in,
    input  logic             tx_send,
    output logic [7:0]       data_out,
    output logic             data_out_valid,
    output logic             ctrl_dac,
    output logic [DAC_W-1:0] dato_dac,
    output logic [CH_W-1:0]  mux_dpot,
    output logic             ctrl_dpot,
    output logic [POT_W-1:0] dato_dpot,
    output logic [1:0]       seg
);
    localparam int         NBYTES  = DAC_W / 8;
    localparam int         TMR_W   = $clog2(TIMEOUT + 1);
    localparam logic [7:0] HDR_DAC = 8'h44;
    localparam logic [7:0] HDR_POT = 8'h50;
    localparam logic [7:0] ACK     = 8'h06;
    localparam logic [7:0] NAK     = 8'h15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_CH   = 2'd1,
        GET_DATA = 2'd2,
        ISSUE    = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             tx_q;
    logic             arm_q;
    logic             pot_q, pot_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [DAC_W-1:0] stage_q, stage_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             nak_q, nak_d;
    logic [DAC_W-1:0] dac_q, dac_d;
    logic [CH_W-1:0]  mux_q, mux_d;
    logic [POT_W-1:0] wip_q, wip_d;
    logic             accept;
    logic [DAC_W-1:0] stage_shift;

    // arm_q blocks a byte when tx_send is already high as reset releases
    assign accept      = tx_send & ~tx_q & arm_q;
    assign stage_shift = (stage_q << 8) | DAC_W'(data_in);

    always_comb begin
        state_d = state_q;
        pot_d   = pot_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        stage_d = stage_q;
        tmr_d   = '0;
        nak_d   = 1'b0;
        dac_d   = dac_q;
        mux_d   = mux_q;
        wip_d   = wip_q;
        unique case (state_q)
            IDLE, ISSUE: begin
                state_d = IDLE;
                if (accept) begin
                    if (data_in == HDR_DAC) begin
                        state_d = GET_DATA;
                        pot_d   = 1'b0;
                        cnt_d   = 3'(NBYTES);
                        stage_d = '0;
                    end else if (data_in == HDR_POT) begin
                        state_d = GET_CH;
                        pot_d   = 1'b1;
                        stage_d = '0;
                    end else begin
                        nak_d = 1'b1;
                    end
                end
            end
            GET_CH: begin
                if (accept) begin
                    if (data_in < 8'(NPOT)) begin
                        ch_d    = data_in[CH_W-1:0];
                        cnt_d   = 3'd1;
                        state_d = GET_DATA;
                    end else begin
                        nak_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    nak_d   = 1'b1;
                    state_d = IDLE;
                    stage_d = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            GET_DATA: begin
                if (accept) begin
                    stage_d = stage_shift;
                    cnt_d   = cnt_q - 3'd1;
                    // held outputs are loaded on the final-byte edge so they are valid alongside the strobe
                    if (cnt_q == 3'd1) begin
                        state_d = ISSUE;
                        if (pot_q) begin
                            mux_d = ch_q;
                            wip_d = data_in;
                        end else begin
                            dac_d = stage_shift;
                        end
                    end
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    nak_d   = 1'b1;
                    state_d = IDLE;
                    stage_d = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tx_q    <= 1'b0;
            arm_q   <= 1'b0;
            pot_q   <= 1'b0;
            cnt_q   <= '0;
            ch_q    <= '0;
            stage_q <= '0;
            tmr_q   <= '0;
            nak_q   <= 1'b0;
            dac_q   <= '0;
            mux_q   <= '0;
            wip_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_send;
            arm_q   <= arm_q | ~tx_send;
            pot_q   <= pot_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            stage_q <= stage_d;
            tmr_q   <= tmr_d;
            nak_q   <= nak_d;
            dac_q   <= dac_d;
            mux_q   <= mux_d;
            wip_q   <= wip_d;
        end
    end

    assign ctrl_dac       = (state_q == ISSUE) & ~pot_q;
    assign ctrl_dpot      = (state_q == ISSUE) & pot_q;
    assign data_out_valid = (state_q == ISSUE) | nak_q;
    assign data_out       = (state_q == ISSUE) ? ACK : (nak_q ? NAK : 8'h00);
    assign dato_dac       = dac_q;
    assign mux_dpot       = mux_q;
    assign dato_dpot      = wip_q;
    assign seg            = state_q;
endmodule

// File: tb/tb_cmd_router.sv
// Bench for cmd_router: two instances (default and DAC_W=24/NPOT=8/TIMEOUT=16) checked every
// cycle against a frame-level reference model, plus directed frames with known results.
module tb_cmd_router;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din [2];
    logic       tx  [2];

    logic [7:0]  do0, do1;
    logic        dv0, dv1, cd0, cd1, cp0, cp1;
    logic [15:0] dac0;
    logic [23:0] dac1;
    logic [1:0]  mux0, seg0, seg1;
    logic [2:0]  mux1;
    logic [7:0]  pot0, pot1;

    int nb   [2] = '{2, 3};
    int npot [2] = '{4, 8};
    int tmo  [2] = '{1000, 16};

    always #5 clk = ~clk;

    cmd_router u_dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(din[0]), .tx_send(tx[0]),
        .data_out(do0), .data_out_valid(dv0), .ctrl_dac(cd0), .dato_dac(dac0),
        .mux_dpot(mux0), .ctrl_dpot(cp0), .dato_dpot(pot0), .seg(seg0)
    );

    cmd_router #(.DAC_W(24), .NPOT(8), .POT_W(8), .TIMEOUT(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(din[1]), .tx_send(tx[1]),
        .data_out(do1), .data_out_valid(dv1), .ctrl_dac(cd1), .dato_dac(dac1),
        .mux_dpot(mux1), .ctrl_dpot(cp1), .dato_dpot(pot1), .seg(seg1)
    );

    logic [31:0] o_do [2], o_dv [2], o_cd [2], o_cp [2], o_dac [2], o_mux [2], o_pot [2], o_seg [2];
    assign o_do[0]  = 32'(do0);   assign o_do[1]  = 32'(do1);
    assign o_dv[0]  = 32'(dv0);   assign o_dv[1]  = 32'(dv1);
    assign o_cd[0]  = 32'(cd0);   assign o_cd[1]  = 32'(cd1);
    assign o_cp[0]  = 32'(cp0);   assign o_cp[1]  = 32'(cp1);
    assign o_dac[0] = 32'(dac0);  assign o_dac[1] = 32'(dac1);
    assign o_mux[0] = 32'(mux0);  assign o_mux[1] = 32'(mux1);
    assign o_pot[0] = 32'(pot0);  assign o_pot[1] = 32'(pot1);
    assign o_seg[0] = 32'(seg0);  assign o_seg[1] = 32'(seg1);

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 20)
                $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame bytes collected so far, idle clocks since last byte,
    // expected held values and the pulse expected in the current cycle (0 none, 1 DAC ack, 2 pot ack, 3 nak).
    logic [7:0]  fb [2][6];
    int          flen   [2];
    int          m_idle [2];
    logic        m_prev [2];
    logic [31:0] e_dac  [2], e_mux [2], e_pot [2];
    int          e_kind [2];
    int          n_ack [2], n_nak [2], n_cdac [2], n_cpot [2];

    task automatic mreset(input int d);
        flen[d] = 0; m_idle[d] = 0; m_prev[d] = 1'b1;
        e_dac[d] = 0; e_mux[d] = 0; e_pot[d] = 0; e_kind[d] = 0;
    endtask

    task automatic model_step(input int d);
        logic        acc;
        logic [31:0] val;
        if (!rst_n) begin
            mreset(d);
        end else begin
            acc = tx[d] && !m_prev[d];
            m_prev[d] = tx[d];
            e_kind[d] = 0;
            if (acc) begin
                m_idle[d] = 0;
                fb[d][flen[d]] = din[d];
                flen[d]++;
                if (fb[d][0] == 8'h44) begin
                    if (flen[d] == nb[d] + 1) begin
                        val = 0;
                        for (int k = 1; k <= nb[d]; k++) val = val * 256 + 32'(fb[d][k]);
                        e_dac[d] = val; e_kind[d] = 1; flen[d] = 0;
                    end
                end else if (fb[d][0] == 8'h50) begin
                    if (flen[d] == 2 && int'(fb[d][1]) >= npot[d]) begin
                        e_kind[d] = 3; flen[d] = 0;
                    end else if (flen[d] == 3) begin
                        e_mux[d] = 32'(fb[d][1]); e_pot[d] = 32'(fb[d][2]);
                        e_kind[d] = 2; flen[d] = 0;
                    end
                end else begin
                    e_kind[d] = 3; flen[d] = 0;
                end
            end else if (flen[d] > 0) begin
                m_idle[d]++;
                if (m_idle[d] == tmo[d]) begin
                    e_kind[d] = 3; flen[d] = 0; m_idle[d] = 0;
                end
            end
        end
    endtask

    task automatic compare(input int d);
        int exp_seg;
        if (e_kind[d] == 1 || e_kind[d] == 2) exp_seg = 3;
        else if (flen[d] == 0)                exp_seg = 0;
        else if (fb[d][0] == 8'h50 && flen[d] == 1) exp_seg = 1;
        else                                  exp_seg = 2;
        chk($sformatf("d%0d seg", d), o_seg[d], 32'(exp_seg));
        chk($sformatf("d%0d data_out_valid", d), o_dv[d], 32'(e_kind[d] != 0));
        if (e_kind[d] != 0)
            chk($sformatf("d%0d data_out", d), o_do[d], (e_kind[d] == 3) ? 32'h15 : 32'h06);
        chk($sformatf("d%0d ctrl_dac", d), o_cd[d], 32'(e_kind[d] == 1));
        chk($sformatf("d%0d ctrl_dpot", d), o_cp[d], 32'(e_kind[d] == 2));
        chk($sformatf("d%0d dato_dac", d), o_dac[d], e_dac[d]);
        chk($sformatf("d%0d mux_dpot", d), o_mux[d], e_mux[d]);
        chk($sformatf("d%0d dato_dpot", d), o_pot[d], e_pot[d]);
        if (o_cd[d] == 1) n_cdac[d]++;
        if (o_cp[d] == 1) n_cpot[d]++;
        if (o_dv[d] == 1 && o_do[d] == 32'h06) n_ack[d]++;
        if (o_dv[d] == 1 && o_do[d] == 32'h15) n_nak[d]++;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            mreset(d);
            n_ack[d] = 0; n_nak[d] = 0; n_cdac[d] = 0; n_cpot[d] = 0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) model_step(d);
            #1;
            for (int d = 0; d < 2; d++) compare(d);
        end
    end

    task automatic send(input int d, input logic [7:0] b, input int h, input int g);
        din[d] = b;
        tx[d]  = 1'b1;
        repeat (h) @(negedge clk);
        tx[d] = 1'b0;
        repeat (g) @(negedge clk);
    endtask

    task automatic chk_zero0(input string tag);
        chk({tag, " seg"}, 32'(seg0), 0);
        chk({tag, " dato_dac"}, 32'(dac0), 0);
        chk({tag, " mux_dpot"}, 32'(mux0), 0);
        chk({tag, " dato_dpot"}, 32'(pot0), 0);
        chk({tag, " strobes"}, {29'd0, dv0, cd0, cp0}, 0);
        chk({tag, " data_out"}, 32'(do0), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int ba, bn, bd, bp, h, g, r;
        logic [7:0] b;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin din[d] = 8'h00; tx[d] = 1'b0; end
        repeat (3) @(negedge clk);
        chk_zero0("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        ba = n_ack[0]; bd = n_cdac[0];
        send(0, 8'h44, 1, 2); send(0, 8'h12, 1, 2); send(0, 8'h34, 1, 3);
        chk("dac write value", 32'(dac0), 32'h1234);
        chk("dac write ack count", 32'(n_ack[0] - ba), 1);
        chk("dac write strobe count", 32'(n_cdac[0] - bd), 1);
        chk("dac write seg idle", 32'(seg0), 0);

        ba = n_ack[0]; bp = n_cpot[0];
        send(0, 8'h50, 1, 2); send(0, 8'h02, 2, 1); send(0, 8'hA5, 1, 3);
        chk("pot write mux", 32'(mux0), 2);
        chk("pot write wiper", 32'(pot0), 32'hA5);
        chk("pot write strobe count", 32'(n_cpot[0] - bp), 1);
        chk("pot write ack count", 32'(n_ack[0] - ba), 1);
        chk("pot write dac held", 32'(dac0), 32'h1234);

        bn = n_nak[0]; bd = n_cdac[0]; bp = n_cpot[0];
        send(0, 8'h74, 1, 3);
        chk("bad header nak", 32'(n_nak[0] - bn), 1);
        chk("bad header seg", 32'(seg0), 0);
        send(0, 8'h50, 1, 2); send(0, 8'h05, 1, 3);
        chk("bad channel nak", 32'(n_nak[0] - bn), 2);
        chk("bad channel seg", 32'(seg0), 0);
        chk("bad frames no strobes", 32'((n_cdac[0] - bd) + (n_cpot[0] - bp)), 0);
        chk("bad frames mux held", 32'(mux0), 2);

        bn = n_nak[0];
        send(0, 8'h44, 1, 2); send(0, 8'h12, 1, 1100);
        chk("timeout nak", 32'(n_nak[0] - bn), 1);
        chk("timeout dac held", 32'(dac0), 32'h1234);
        send(0, 8'h44, 1, 2); send(0, 8'hAB, 1, 2); send(0, 8'hCD, 1, 3);
        chk("after timeout dac", 32'(dac0), 32'hABCD);

        din[0] = 8'h44; tx[0] = 1'b1;
        repeat (10) @(negedge clk);
        chk("held tx_send seg", 32'(seg0), 2);
        rst_n = 1'b0;
        #1;
        chk_zero0("async reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no byte without fresh edge", 32'(seg0), 0);
        tx[0] = 1'b0;
        repeat (2) @(negedge clk);

        send(1, 8'h44, 1, 1); send(1, 8'h01, 1, 1); send(1, 8'h02, 1, 1); send(1, 8'h03, 1, 3);
        chk("wide dac value", 32'(dac1), 32'h010203);
        send(1, 8'h50, 1, 1); send(1, 8'h07, 1, 1); send(1, 8'h3C, 1, 3);
        chk("wide pot mux", 32'(mux1), 7);
        chk("wide pot wiper", 32'(pot1), 32'h3C);

        for (int i = 0; i < 800; i++) begin
            int d;
            d = i % 2;
            r = int'($urandom_range(0, 9));
            if (r < 3)      b = 8'h44;
            else if (r < 5) b = 8'h50;
            else if (r < 7) b = 8'($urandom_range(0, 9));
            else            b = 8'($urandom);
            h = int'($urandom_range(1, 3));
            g = int'($urandom_range(1, 3));
            if (d == 1 && $urandom_range(0, 9) == 0)
                g = tmo[1] - h - 1 + int'($urandom_range(0, 2));
            else if (d == 0 && $urandom_range(0, 79) == 0)
                g = tmo[0] - h - 1 + int'($urandom_range(0, 2));
            send(d, b, h, g);
        end
        repeat (1100) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
